// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared state encoding and helpers for the clock-enable divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } clk_div_state_e;

    // ceil(d/2): number of high cycles of div_clk for a ratio of d
    function automatic logic [31:0] half_up(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/clk_div_counter.sv
// ============================================================================
// Module   : clk_div_counter
// Purpose  : Period counter with tick / divided-phase decode from its flops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [DIV_W-1:0] cnt_o,
    output logic             tick_o,
    output logic             div_clk_o
);

    localparam logic [DIV_W-1:0] c_one = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             w_last;

    assign w_last = (cnt_q == (div_i - c_one));

    always_comb begin
        cnt_d = cnt_q + c_one;
        if (clr_i || !run_i || w_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign tick_o    = run_i && w_last;
    assign div_clk_o = run_i && (32'(cnt_q) < half_up(32'(div_i)));

endmodule : clk_div_counter

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module   : clk_div_ctrl
// Purpose  : Runtime-reconfigurable clock-enable generator with req/ack
//            handshake; ratio changes land only on period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 10,
    parameter bit RESET_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             tick,
    output logic             div_clk,
    output logic             running,
    output logic [DIV_W-1:0] cur_div
);

    localparam logic [DIV_W-1:0] c_reset_div = DIV_W'(RESET_DIV);

    clk_div_state_e   state_q;
    logic [DIV_W-1:0] cur_div_q;
    logic             ack_q;
    logic             err_q;

    logic             w_req_ok;
    logic             w_apply;
    logic             w_tick;
    logic             w_div_clk;
    logic             w_running;
    logic [DIV_W-1:0] w_cnt;

    // A request seen during the ack cycle is the one just accepted; ignore it.
    assign w_req_ok  = cfg_req && !ack_q;
    assign w_running = (state_q != STOP);

    always_comb begin
        w_apply = 1'b0;
        case (state_q)
            STOP:    w_apply = w_req_ok;
            PEND:    w_apply = w_tick;
            default: w_apply = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_EN ? RUN : STOP;
            cur_div_q <= c_reset_div;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= w_apply;
            err_q <= w_apply && (cfg_div == '0);
            if (w_apply) begin
                if (cfg_div != '0) begin
                    cur_div_q <= cfg_div;
                    state_q   <= cfg_en ? RUN : STOP;
                end else begin
                    // Zero ratio is rejected: keep the old ratio and run state.
                    state_q <= (state_q == STOP) ? STOP : RUN;
                end
            end else if ((state_q == RUN) && w_req_ok) begin
                state_q <= PEND;
            end
        end
    end

    clk_div_counter #(
        .DIV_W (DIV_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .run_i     (w_running),
        .clr_i     (w_apply),
        .div_i     (cur_div_q),
        .cnt_o     (w_cnt),
        .tick_o    (w_tick),
        .div_clk_o (w_div_clk)
    );

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;
    assign tick    = w_tick;
    assign div_clk = w_div_clk;
    assign running = w_running;
    assign cur_div = cur_div_q;

endmodule : clk_div_ctrl

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module   : tb_clk_div_ctrl
// Purpose  : Directed self-checking bench for clk_div_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_req;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       cfg_ack;
    logic       cfg_err;
    logic       tick;
    logic       div_clk;
    logic       running;
    logic [7:0] cur_div;

    int checks = 0;
    int errors = 0;

    // Expected-state tracker: period position, ratio, run flag, handshake pulses
    int ecnt;
    int ediv;
    bit erun;
    bit eack;
    bit eerr;

    always #5 clk = ~clk;

    clk_div_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_req (cfg_req),
        .cfg_div (cfg_div),
        .cfg_en  (cfg_en),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .tick    (tick),
        .div_clk (div_clk),
        .running (running),
        .cur_div (cur_div)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cnt=%0d div=%0d)", tag, obs, exp, ecnt, ediv);
        end
    endtask

    task automatic chk_all();
        chk("tick",    32'(tick),    (erun && ecnt == ediv - 1) ? 32'd1 : 32'd0);
        chk("div_clk", 32'(div_clk), (erun && ecnt < (ediv + 1) / 2) ? 32'd1 : 32'd0);
        chk("running", 32'(running), 32'(erun));
        chk("cur_div", 32'(cur_div), 32'(ediv));
        chk("cfg_ack", 32'(cfg_ack), 32'(eack));
        chk("cfg_err", 32'(cfg_err), 32'(eerr));
    endtask

    task automatic adv();
        if (erun) ecnt = (ecnt == ediv - 1) ? 0 : ecnt + 1;
        else      ecnt = 0;
        eack = 1'b0;
        eerr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            chk_all();
            adv();
        end
    endtask

    // Issue a request, wait the expected handshake latency, check the ack cycle,
    // keep the request high through the ack cycle, then drop it.
    task automatic request(input int div, input bit en);
        int n;
        cfg_req = 1'b1;
        cfg_div = 8'(div);
        cfg_en  = en;
        if (!erun)                  n = 1;
        else if (ecnt == ediv - 1)  n = ediv + 1;
        else                        n = ediv - ecnt;
        cyc(n);
        if (div != 0) begin
            ediv = div;
            erun = en;
        end
        ecnt = 0;
        eack = 1'b1;
        eerr = (div == 0);
        chk_all();
        adv();
        cfg_req = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        cfg_req = 1'b0;
        cfg_div = 8'd0;
        cfg_en  = 1'b0;
        ecnt = 0; ediv = 10; erun = 1'b1; eack = 1'b0; eerr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then default ratio 10: ticks at 9,19,29,39
        chk("rst_div_clk", 32'(div_clk), 32'd1);
        chk("rst_cur_div", 32'(cur_div), 32'd10);
        cyc(40);

        // Request ratio 4 at cnt=3: old period finishes at cnt 9, no short period
        cyc(3);
        cfg_req = 1'b1;
        cfg_div = 8'd4;
        cfg_en  = 1'b1;
        cyc(7);
        ediv = 4;
        eack = 1'b1;
        chk_all();
        chk("ack_cycle_cnt0_div_clk", 32'(div_clk), 32'd1);
        adv();
        cfg_req = 1'b0;
        cyc(12);

        // Ratio 3 (div_clk 1,1,0), then ratio 1 (tick and div_clk always high)
        request(3, 1'b1);
        cyc(9);
        request(1, 1'b1);
        chk("d1_tick", 32'(tick), 32'd1);
        cyc(5);

        // Stop request, then run at ratio 5 from STOP
        request(4, 1'b0);
        cyc(5);
        request(5, 1'b1);
        cyc(10);

        // Zero ratio while running at 6: error pulse, ratio unchanged
        request(6, 1'b1);
        cyc(8);
        request(0, 1'b1);
        chk("err_keeps_div", 32'(cur_div), 32'd6);
        cyc(14);

        // Reset while a request is pending: no ack, reset values restored
        cfg_req = 1'b1;
        cfg_div = 8'd2;
        cfg_en  = 1'b1;
        cyc(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cfg_req = 1'b0;
        ecnt = 0; ediv = 10; erun = 1'b1; eack = 1'b0; eerr = 1'b0;
        cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_ctrl

`default_nettype wire

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-enable generator and reconfiguration controller for the testbench and RTL clocking path. It turns the single system clock into a divided tick/phase pair and owns all changes to the divide ratio through a req/ack handshake. Changes are applied only at period boundaries, so downstream logic never sees a truncated or glitched period. It replaces free-running `#delay` clock loops wherever a synthesizable, runtime-reconfigurable rate is needed.

## Interface
- `DIV_W`, 8: width of the divide ratio.
- `RESET_DIV`, 10: divide ratio after reset. Must be nonzero and fit in `DIV_W`.
- `RESET_EN`, 1: 1 means running after reset; 0 means stopped.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_req` in 1: reconfiguration request. Held high until `cfg_ack`.
- `cfg_div` in `DIV_W`: requested ratio D. Stable while `cfg_req` is high.
- `cfg_en` in 1: requested run (1) or stop (0). Stable while `cfg_req` is high.
- `cfg_ack` out 1: one-cycle accept pulse.
- `cfg_err` out 1: one-cycle pulse together with `cfg_ack` when `cfg_div == 0`.
- `tick` out 1: one-cycle pulse, once per D cycles while running.
- `div_clk` out 1: divided phase level.
- `running` out 1: high in RUN and PEND.
- `cur_div` out `DIV_W`: active ratio.

## Operation
- Internal counter `cnt` (`DIV_W` bits) counts 0..D-1 while running, then wraps to 0.
- `tick` = running && `cnt == D-1`. For D=1, `tick` is high every cycle.
- `div_clk` = running && `cnt < ceil(D/2)`. For D=1, `div_clk` is constantly 1. Duty cycle is ceil(D/2) high / floor(D/2) low.
- States:
  - STOP: `cnt` = 0; `tick`, `div_clk` and `running` are 0. If `cfg_req` is high (and `cfg_ack` is not high), apply at the next edge.
  - RUN: counting. If `cfg_req` is high and `cfg_ack` is low, go to PEND; counting continues.
  - PEND: counting. At the edge ending the `tick` cycle, apply.
- Apply (one edge):
  - If `cfg_div != 0`: latch `cur_div` = `cfg_div`, set `cnt` = 0, and go to RUN if `cfg_en`, else STOP.
  - If `cfg_div == 0`: keep the old `cur_div` and enable; if previously running, `cnt` = 0 and RUN; assert `cfg_err`.
  - In both cases `cfg_ack` = 1 for the following cycle only.
- `cfg_req` is ignored in any cycle where `cfg_ack` is high. This prevents double acceptance before the requester drops the request.
- A stop request waits for the current period to complete, then `tick` and `div_clk` drop to 0.
- A request of the same ratio still waits for the boundary and acks; the period is not lengthened.

## Timing
- Reset values: state RUN if `RESET_EN` else STOP; `cnt` = 0; `cur_div` = `RESET_DIV`; `cfg_ack` = `cfg_err` = 0. With `RESET_EN` = 1: `running` = 1, `div_clk` = 1, and `tick` is high only if `RESET_DIV` = 1.
- First cycle after `rst` falls is `cnt` = 0. The first `tick` is at cycle D-1.
- Reset mid-PEND drops the pending request with no ack. The requester must re-request.
- Ack latency:
  - From STOP: 1 cycle after `cfg_req` is first sampled.
  - From RUN: 1 cycle after the current period's `tick`. Worst case is D+1 cycles.
- The new ratio's `cnt` = 0 cycle coincides with `cfg_ack` high. There is no gap cycle between the old and new periods.
- All outputs derive from flops only (`tick` and `div_clk` are decoded from registered state). No combinational path from inputs to outputs.

## Structure
- Package `clk_div_pkg`: state enum `clk_div_state_e` {STOP, RUN, PEND}, and a function `half_up(d)` returning ceil(d/2).
- Sub-module `clk_div_counter`: holds `cnt` and decodes `tick`/`div_clk` from `cur_div`, `running` and a synchronous clear.
- `clk_div_ctrl` holds the FSM, config registers and handshake.

## Test plan
- Reset with defaults, run 40 cycles -> `tick` at cycles 9, 19, 29, 39; `div_clk` high for cycles 0-4 of each period, low for 5-9.
- D=10, raise `cfg_req` with `cfg_div` = 4 at `cnt` = 3 -> `tick` at `cnt` = 9, `cfg_ack` the next cycle with `cnt` = 0, then `tick` every 4 cycles; no short period.
- `cfg_div` = 3 -> `div_clk` pattern 1,1,0 repeating. `cfg_div` = 1 -> `tick` and `div_clk` constantly 1.
- Stop request (`cfg_en` = 0) -> the current period completes, `cfg_ack` fires, `running`, `tick` and `div_clk` are 0. A later run request with `cfg_div` = 5 -> ack 1 cycle later, first `tick` 4 cycles after that.
- `cfg_div` = 0 while running at D=6 -> `cfg_ack` and `cfg_err` pulse together at the boundary; the ratio stays 6 and ticking continues.
- Assert `rst` during PEND -> no `cfg_ack`; reset values restored on the next cycle. `cfg_req` held through the `cfg_ack` cycle produces exactly one ack.
